// File: rtl/bpf_sched_pkg.sv
// Shared types and constants for the multi-core BPF scheduler.
package bpf_sched_pkg;

    // Life cycle of one core/buffer pair.
    typedef enum logic [1:0] {
        CORE_FREE = 2'd0,
        CORE_FILL = 2'd1,
        CORE_RUN  = 2'd2,
        CORE_DONE = 2'd3
    } core_state_e;

    // Verdict encoding as seen on res_acc.
    localparam logic VERDICT_ACC = 1'b1;
    localparam logic VERDICT_REJ = 1'b0;

    localparam int          TO_CNT_W   = 16;
    localparam logic [15:0] TO_CNT_MAX = 16'hFFFF;

    // Accept only on a clean accept; a simultaneous reject wins.
    function automatic logic resolve_verdict(input logic acc, input logic rej);
        return (acc && !rej) ? VERDICT_ACC : VERDICT_REJ;
    endfunction

endpackage

// File: rtl/bpf_order_fifo.sv
// Small index FIFO recording packet arrival order (one entry per busy core).
module bpf_order_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];
    assign empty  = (count == '0);

    // Pointers, occupancy and storage; storage is cleared so head reads 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bpf_core_sched.sv
// Multi-core BPF front end: allocates core/buffer pairs to ingest, starts
// cores, watchdogs them, and releases verdicts in packet arrival order.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   CORE_FREE | idle, may be allocated to ingest
//   CORE_FILL | buffer being written by ingest (at most one core)
//   CORE_RUN  | program executing, watchdog counting
//   CORE_DONE | verdict latched, waiting for its turn on the result port
module bpf_core_sched
    import bpf_sched_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int IDX_W          = $clog2(N_CORES),
    parameter int LEN_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     alloc_valid,
    output logic [IDX_W-1:0]         wr_idx,
    input  logic                     pkt_done,
    input  logic [LEN_W-1:0]         pkt_len,
    output logic [N_CORES-1:0]       core_start,
    output logic [N_CORES*LEN_W-1:0] core_len,
    output logic [N_CORES-1:0]       core_abort,
    input  logic [N_CORES-1:0]       core_acc,
    input  logic [N_CORES-1:0]       core_rej,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_acc,
    output logic [IDX_W-1:0]         res_idx,
    output logic [LEN_W-1:0]         res_len,
    output logic [TO_CNT_W-1:0]      timeout_cnt
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [N_CORES-1:0] fill_vec;
    logic [N_CORES-1:0] free_vec;
    logic [N_CORES-1:0] done_vec;
    logic [N_CORES-1:0] verdict_vec;
    logic [N_CORES-1:0] abort_ev_vec;
    logic [N_CORES-1:0] alloc_sel;
    logic [LEN_W-1:0]   len_arr [N_CORES];
    logic               alloc_found;
    logic               any_fill;
    logic               pkt_take;
    logic               res_pop;
    logic               fifo_empty;
    logic [IDX_W-1:0]   head_idx;
    logic [16:0]        abort_sum;
    logic [16:0]        to_sum;

    assign any_fill    = |fill_vec;
    assign alloc_valid = any_fill;
    assign pkt_take    = pkt_done && any_fill;

    // Lowest-index free core is claimed only while no core is filling.
    always_comb begin
        alloc_sel   = '0;
        alloc_found = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            if (!any_fill && !alloc_found && free_vec[k]) begin
                alloc_sel[k] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
    end

    // Encode the (single) filling core onto wr_idx; 0 when none.
    always_comb begin
        wr_idx = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (fill_vec[k]) begin
                wr_idx = IDX_W'(k);
            end
        end
    end

    bpf_order_fifo #(
        .DEPTH (N_CORES),
        .WIDTH (IDX_W)
    ) u_order_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pkt_take),
        .push_data (wr_idx),
        .pop       (res_pop),
        .head      (head_idx),
        .empty     (fifo_empty)
    );

    // Result port always reflects the oldest outstanding packet.
    assign res_valid = !fifo_empty && done_vec[head_idx];
    assign res_pop   = res_valid && res_ready;
    assign res_acc   = verdict_vec[head_idx];
    assign res_idx   = head_idx;
    assign res_len   = len_arr[head_idx];

    for (genvar i = 0; i < N_CORES; i++) begin : g_core
        core_state_e      state_q;
        core_state_e      state_d;
        logic [WD_W-1:0]  wd_q;
        logic [WD_W-1:0]  wd_d;
        logic             verdict_q;
        logic             verdict_d;
        logic [LEN_W-1:0] len_q;
        logic             start_q;
        logic             abort_q;
        logic             start_ev;
        logic             abort_ev;
        logic             take;
        logic             release_core;
        logic             is_free;
        logic             is_fill;
        logic             is_done;

        assign take         = pkt_take && (state_q == CORE_FILL);
        assign release_core = res_pop && (head_idx == IDX_W'(i));

        // State register with watchdog, verdict, length and pulse flops.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q   <= CORE_FREE;
                wd_q      <= '0;
                verdict_q <= VERDICT_REJ;
                len_q     <= '0;
                start_q   <= 1'b0;
                abort_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                wd_q      <= wd_d;
                verdict_q <= verdict_d;
                start_q   <= start_ev;
                abort_q   <= abort_ev;
                if (take) begin
                    len_q <= pkt_len;
                end
            end
        end

        // Next-state logic; a verdict in the expiry cycle beats the watchdog.
        always_comb begin
            state_d   = state_q;
            wd_d      = wd_q;
            verdict_d = verdict_q;
            start_ev  = 1'b0;
            abort_ev  = 1'b0;
            case (state_q)
                CORE_FREE: begin
                    if (alloc_sel[i]) begin
                        state_d = CORE_FILL;
                    end
                end
                CORE_FILL: begin
                    if (take) begin
                        if (pkt_len != '0) begin
                            state_d  = CORE_RUN;
                            wd_d     = '0;
                            start_ev = 1'b1;
                        end else begin
                            state_d   = CORE_DONE;
                            verdict_d = VERDICT_REJ;
                        end
                    end
                end
                CORE_RUN: begin
                    if (core_acc[i] || core_rej[i]) begin
                        state_d   = CORE_DONE;
                        verdict_d = resolve_verdict(core_acc[i], core_rej[i]);
                    end else if (wd_q == WD_LAST) begin
                        state_d   = CORE_DONE;
                        verdict_d = VERDICT_REJ;
                        abort_ev  = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                CORE_DONE: begin
                    if (release_core) begin
                        state_d = CORE_FREE;
                    end
                end
                default: state_d = CORE_FREE;
            endcase
        end

        // Output decode of the per-core state.
        always_comb begin
            is_free = (state_q == CORE_FREE);
            is_fill = (state_q == CORE_FILL);
            is_done = (state_q == CORE_DONE);
        end

        assign free_vec[i]                   = is_free;
        assign fill_vec[i]                   = is_fill;
        assign done_vec[i]                   = is_done;
        assign verdict_vec[i]                = verdict_q;
        assign abort_ev_vec[i]               = abort_ev;
        assign len_arr[i]                    = len_q;
        assign core_len[i*LEN_W +: LEN_W]    = len_q;
        assign core_start[i]                 = start_q;
        assign core_abort[i]                 = abort_q;
    end

    // Several cores may expire together; add them all, then saturate.
    always_comb begin
        abort_sum = '0;
        for (int k = 0; k < N_CORES; k++) begin
            abort_sum = abort_sum + 17'(abort_ev_vec[k]);
        end
        to_sum = {1'b0, timeout_cnt} + abort_sum;
    end

    // Saturating watchdog-abort counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= to_sum[16] ? TO_CNT_MAX : to_sum[15:0];
        end
    end

endmodule

// File: tb/tb_bpf_core_sched.sv
// Bench for bpf_core_sched: directed scenarios with literal expectations,
// then random traffic, all checked each cycle against a behavioural model.
module tb_bpf_core_sched;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int LW = 32;
    localparam int T  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            alloc_valid;
    logic [IW-1:0]   wr_idx;
    logic            pkt_done = 1'b0;
    logic [LW-1:0]   pkt_len = '0;
    logic [N-1:0]    core_start;
    logic [N*LW-1:0] core_len;
    logic [N-1:0]    core_abort;
    logic [N-1:0]    core_acc = '0;
    logic [N-1:0]    core_rej = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic            res_acc;
    logic [IW-1:0]   res_idx;
    logic [LW-1:0]   res_len;
    logic [15:0]     timeout_cnt;

    always #5 clk = ~clk;

    bpf_core_sched #(
        .N_CORES        (N),
        .IDX_W          (IW),
        .LEN_W          (LW),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_valid (alloc_valid),
        .wr_idx      (wr_idx),
        .pkt_done    (pkt_done),
        .pkt_len     (pkt_len),
        .core_start  (core_start),
        .core_len    (core_len),
        .core_abort  (core_abort),
        .core_acc    (core_acc),
        .core_rej    (core_rej),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_acc     (res_acc),
        .res_idx     (res_idx),
        .res_len     (res_len),
        .timeout_cnt (timeout_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: which cores are owned, running, finished, and the arrival queue.
    int           m_fill;
    bit           m_inuse [N];
    bit           m_run   [N];
    bit           m_done  [N];
    bit           m_acc   [N];
    int           m_age   [N];
    logic [LW-1:0] m_len  [N];
    int           q [$];
    logic [N-1:0] m_start;
    logic [N-1:0] m_abort;
    int           m_tocnt;

    task automatic model_reset();
        m_fill = -1;
        for (int c = 0; c < N; c++) begin
            m_inuse[c] = 0; m_run[c] = 0; m_done[c] = 0; m_acc[c] = 0;
            m_age[c] = 0; m_len[c] = '0;
        end
        q.delete();
        m_start = '0;
        m_abort = '0;
        m_tocnt = 0;
    endtask

    function automatic bit model_rv();
        if (q.size() == 0) return 0;
        return m_done[q[0]];
    endfunction

    task automatic compare_outputs();
        bit rv;
        rv = model_rv();
        chk("alloc_valid", 64'(alloc_valid), 64'(m_fill >= 0));
        if (m_fill >= 0) chk("wr_idx", 64'(wr_idx), 64'(m_fill));
        chk("core_start", 64'(core_start), 64'(m_start));
        chk("core_abort", 64'(core_abort), 64'(m_abort));
        chk("res_valid", 64'(res_valid), 64'(rv));
        chk("timeout_cnt", 64'(timeout_cnt), 64'(m_tocnt));
        if (rv) begin
            chk("res_idx", 64'(res_idx), 64'(q[0]));
            chk("res_acc", 64'(res_acc), 64'(m_acc[q[0]]));
            chk("res_len", 64'(res_len), 64'(m_len[q[0]]));
        end
        for (int c = 0; c < N; c++) begin
            chk("core_len", 64'(core_len[c*LW +: LW]), 64'(m_len[c]));
        end
    endtask

    // Advance the model by one clock using the inputs present this cycle.
    task automatic model_step();
        bit was_run [N];
        bit rv;
        int alloc_c;
        int c;
        rv = model_rv();
        for (int k = 0; k < N; k++) was_run[k] = m_run[k];
        m_start = '0;
        m_abort = '0;
        alloc_c = -1;
        if (m_fill < 0) begin
            for (int k = 0; k < N; k++) if (!m_inuse[k] && alloc_c < 0) alloc_c = k;
        end
        if (pkt_done && m_fill >= 0) begin
            c = m_fill;
            m_len[c] = pkt_len;
            q.push_back(c);
            if (pkt_len == 0) begin
                m_done[c] = 1; m_acc[c] = 0;
            end else begin
                m_run[c] = 1; m_age[c] = 0; m_start[c] = 1'b1;
            end
            m_fill = -1;
        end
        for (int k = 0; k < N; k++) begin
            if (was_run[k]) begin
                if (core_acc[k] || core_rej[k]) begin
                    m_run[k] = 0; m_done[k] = 1; m_acc[k] = core_acc[k] && !core_rej[k];
                end else if (m_age[k] == T - 1) begin
                    m_run[k] = 0; m_done[k] = 1; m_acc[k] = 0; m_abort[k] = 1'b1;
                    if (m_tocnt < 65535) m_tocnt++;
                end else begin
                    m_age[k]++;
                end
            end
        end
        if (rv && res_ready) begin
            c = q.pop_front();
            m_done[c] = 0;
            m_inuse[c] = 0;
        end
        if (alloc_c >= 0) begin
            m_inuse[alloc_c] = 1;
            m_fill = alloc_c;
        end
    endtask

    // Per-cycle comparison against the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst) begin
                model_reset();
                chk("rst_alloc_valid", 64'(alloc_valid), 64'(0));
                chk("rst_res_valid", 64'(res_valid), 64'(0));
                chk("rst_timeout_cnt", 64'(timeout_cnt), 64'(0));
            end else begin
                compare_outputs();
                model_step();
            end
        end
    end

    task automatic drive(input bit pd, input logic [LW-1:0] len, input logic [N-1:0] a,
                         input logic [N-1:0] r, input bit rdy);
        @(posedge clk);
        #1;
        pkt_done  = pd;
        pkt_len   = len;
        core_acc  = a;
        core_rej  = r;
        res_ready = rdy;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_alloc_valid"}, 64'(alloc_valid), 64'(0));
        chk({tag, "_wr_idx"}, 64'(wr_idx), 64'(0));
        chk({tag, "_core_start"}, 64'(core_start), 64'(0));
        chk({tag, "_core_abort"}, 64'(core_abort), 64'(0));
        chk({tag, "_res_valid"}, 64'(res_valid), 64'(0));
        chk({tag, "_res_acc"}, 64'(res_acc), 64'(0));
        chk({tag, "_res_idx"}, 64'(res_idx), 64'(0));
        chk({tag, "_res_len"}, 64'(res_len), 64'(0));
        chk({tag, "_timeout_cnt"}, 64'(timeout_cnt), 64'(0));
        for (int c = 0; c < N; c++) chk({tag, "_core_len"}, 64'(core_len[c*LW +: LW]), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Allocation after reset and first packet
        @(posedge clk); #1; rst = 1'b1;
        idle();                 @(negedge clk);
        chk("t1_alloc_valid", 64'(alloc_valid), 64'(1));
        chk("t1_wr_idx0", 64'(wr_idx), 64'(0));
        drive(1'b1, 32'd64, '0, '0, 1'b0);
        idle();                 @(negedge clk);
        chk("t1_core_start", 64'(core_start), 64'(4'b0001));
        chk("t1_core_len0", 64'(core_len[31:0]), 64'(64));
        chk("t1_alloc_gap", 64'(alloc_valid), 64'(0));
        idle();                 @(negedge clk);
        chk("t1_alloc_again", 64'(alloc_valid), 64'(1));
        chk("t1_wr_idx1", 64'(wr_idx), 64'(1));

        // In-order release: core1 accepts before core0 rejects
        drive(1'b1, 32'd100, '0, '0, 1'b0);
        idle();
        drive(1'b0, '0, 4'b0010, '0, 1'b0);
        idle();                 @(negedge clk);
        chk("t2_held_back", 64'(res_valid), 64'(0));
        drive(1'b0, '0, '0, 4'b0001, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1); @(negedge clk);
        chk("t2_first_valid", 64'(res_valid), 64'(1));
        chk("t2_first_idx", 64'(res_idx), 64'(0));
        chk("t2_first_acc", 64'(res_acc), 64'(0));
        chk("t2_first_len", 64'(res_len), 64'(64));
        drive(1'b0, '0, '0, '0, 1'b1); @(negedge clk);
        chk("t2_second_valid", 64'(res_valid), 64'(1));
        chk("t2_second_idx", 64'(res_idx), 64'(1));
        chk("t2_second_acc", 64'(res_acc), 64'(1));
        chk("t2_second_len", 64'(res_len), 64'(100));

        // Watchdog expiry on core2
        drive(1'b1, 32'd7, '0, '0, 1'b0); @(negedge clk);
        chk("t3_empty", 64'(res_valid), 64'(0));
        idle();                 @(negedge clk);
        chk("t3_start", 64'(core_start), 64'(4'b0100));
        repeat (15) idle();
        @(negedge clk);
        chk("t3_no_early_abort", 64'(core_abort), 64'(0));
        drive(1'b0, '0, '0, '0, 1'b1); @(negedge clk);
        chk("t3_abort", 64'(core_abort), 64'(4'b0100));
        chk("t3_timeout_cnt", 64'(timeout_cnt), 64'(1));
        chk("t3_res_valid", 64'(res_valid), 64'(1));
        chk("t3_res_idx", 64'(res_idx), 64'(2));
        chk("t3_res_acc", 64'(res_acc), 64'(0));
        chk("t3_res_len", 64'(res_len), 64'(7));

        // Fill every core, extra packet ignored, freed core reappears
        drive(1'b1, 32'd10, '0, '0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            idle();
            drive(1'b1, 32'(10 + k), '0, '0, 1'b0);
        end
        idle();                 @(negedge clk);
        chk("t4_all_busy", 64'(alloc_valid), 64'(0));
        drive(1'b1, 32'd99, '0, '0, 1'b0); @(negedge clk);
        chk("t4_all_busy2", 64'(alloc_valid), 64'(0));
        drive(1'b0, '0, 4'b1111, '0, 1'b0); @(negedge clk);
        chk("t4_ignored_no_start", 64'(core_start), 64'(0));
        drive(1'b0, '0, '0, '0, 1'b1); @(negedge clk);
        chk("t4_res_valid", 64'(res_valid), 64'(1));
        chk("t4_res_idx", 64'(res_idx), 64'(0));
        chk("t4_res_acc", 64'(res_acc), 64'(1));
        chk("t4_res_len", 64'(res_len), 64'(10));
        idle();                 @(negedge clk);
        chk("t4_not_yet", 64'(alloc_valid), 64'(0));
        drive(1'b0, '0, '0, '0, 1'b1); @(negedge clk);
        chk("t4_realloc", 64'(alloc_valid), 64'(1));
        chk("t4_realloc_idx", 64'(wr_idx), 64'(0));
        drive(1'b0, '0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b1);

        // Zero-length packet and simultaneous accept/reject
        drive(1'b1, 32'd0, '0, '0, 1'b0);
        idle();                 @(negedge clk);
        chk("t5_no_start", 64'(core_start), 64'(0));
        chk("t5_res_valid", 64'(res_valid), 64'(1));
        chk("t5_res_idx", 64'(res_idx), 64'(0));
        chk("t5_res_acc", 64'(res_acc), 64'(0));
        chk("t5_res_len", 64'(res_len), 64'(0));
        drive(1'b1, 32'd5, '0, '0, 1'b0); @(negedge clk);
        chk("t5_wr_idx", 64'(wr_idx), 64'(1));
        drive(1'b0, '0, 4'b0010, 4'b0010, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b1); @(negedge clk);
        chk("t5_both_valid", 64'(res_valid), 64'(1));
        chk("t5_both_idx", 64'(res_idx), 64'(1));
        chk("t5_both_acc", 64'(res_acc), 64'(0));
        chk("t5_both_len", 64'(res_len), 64'(5));

        // Asynchronous reset with a verdict pending
        begin
            int k;
            for (k = 0; k < 20; k++) begin
                idle();
                @(negedge clk);
                if (alloc_valid) break;
            end
            chk("t6_alloc_wait", 64'(k < 20), 64'(1));
        end
        drive(1'b1, 32'd8, '0, '0, 1'b0);
        idle();
        drive(1'b0, '0, 4'b1111, '0, 1'b0);
        idle();                 @(negedge clk);
        chk("t6_pending", 64'(res_valid), 64'(1));
        @(posedge clk); #3; rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("t6_release_gap", 64'(alloc_valid), 64'(0));
        idle();                 @(negedge clk);
        chk("t6_restart", 64'(alloc_valid), 64'(1));
        chk("t6_restart_idx", 64'(wr_idx), 64'(0));

        // Random traffic against the model
        repeat (3000) begin
            bit           pd;
            int           sel;
            logic [LW-1:0] len;
            logic [N-1:0] a;
            logic [N-1:0] r;
            bit           rdy;
            pd  = ($urandom_range(0, 9) < 4);
            sel = $urandom_range(0, 3);
            len = (sel == 0) ? '0 : (sel == 1) ? LW'($urandom_range(1, 1500)) : LW'($urandom);
            for (int b = 0; b < N; b++) begin
                a[b] = ($urandom_range(0, 19) == 0);
                r[b] = ($urandom_range(0, 23) == 0);
            end
            rdy = ($urandom_range(0, 2) != 0);
            drive(pd, len, a, r, rdy);
        end
        idle();
        idle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bpf_core_sched.md
Name: bpf_core_sched

Overview:
- Next-generation multi-core front end for the BPF CPU core: manages N_CORES cores, each paired with its own packet buffer.
- Allocates a free core/buffer to the packet ingest side and starts the core when the packet is complete.
- Collects accept/reject verdicts, kills runaway programs with a per-core watchdog, and releases verdicts strictly in packet arrival order to the forwarder.

Parameters:
N_CORES, 4, number of CPU cores/buffers (2..16)
IDX_W, $clog2(N_CORES), core index width
LEN_W, 32, packet length width
TIMEOUT_CYCLES, 4096, max cycles from core start to verdict before forced reject (>=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
alloc_valid  out  1  a core is assigned to ingest (wr_idx valid)
wr_idx  out  IDX_W  buffer/core the ingest must write into
pkt_done  in  1  pulse: packet in wr_idx buffer complete; ignored unless alloc_valid
pkt_len  in  LEN_W  byte length, sampled with pkt_done
core_start  out  N_CORES  one-cycle start pulse per core
core_len  out  N_CORES*LEN_W  latched length per core, slice i for core i
core_abort  out  N_CORES  one-cycle abort pulse on timeout
core_acc  in  N_CORES  per-core accept pulse
core_rej  in  N_CORES  per-core reject pulse
res_valid  out  1  head-of-order verdict available
res_ready  in  1  forwarder consumed verdict; frees the core
res_acc  out  1  1 = accept, 0 = reject
res_idx  out  IDX_W  buffer holding the packet
res_len  out  LEN_W  packet length
timeout_cnt  out  16  saturating count of watchdog aborts

Behaviour:
- Reset (rst low, async): all cores FREE, order FIFO empty, every output 0, wr_idx 0, core_len 0, timeout_cnt 0.
- Per-core FSM: FREE -> FILL (allocated) -> RUN -> DONE -> FREE.
- Allocation: when no core is in FILL, the lowest-index FREE core goes to FILL on the next edge. alloc_valid = (some core in FILL); wr_idx = that core. At most one core is in FILL.
- pkt_done while alloc_valid, cycle t:
  - core_len[wr_idx] <= pkt_len.
  - wr_idx pushed to order FIFO.
  - pkt_len != 0: core enters RUN at t+1, core_start pulses at t+1, watchdog cleared to 0.
  - pkt_len == 0: core enters DONE directly with verdict reject; no start pulse.
  - Next FREE core is allocated at t+1 (alloc_valid low for cycle t+1, high at t+2 if a core is free).
- Verdicts in RUN:
  - core_acc or core_rej at cycle t -> DONE at t+1, verdict latched.
  - acc and rej together -> reject.
  - Pulses while a core is not in RUN are ignored.
- Watchdog: counts each cycle in RUN. Reaching TIMEOUT_CYCLES-1 with no verdict that cycle -> core_abort pulse next cycle, DONE with reject, timeout_cnt += 1 (saturates at 0xFFFF). A verdict arriving in the same cycle as expiry wins; no abort.
- Order FIFO: depth N_CORES, holds core indices. Cannot overflow since each entry owns a distinct core.
- Result port:
  - res_valid = FIFO non-empty and head core in DONE; res_acc/res_idx/res_len come from the head.
  - Outputs hold stable while res_valid && !res_ready.
  - On res_valid && res_ready: pop FIFO; head core -> FREE at the next edge. It is not allocatable until the following cycle.
  - Later-arriving packets that finish first wait behind the head (no reordering).
- All cores busy: alloc_valid low; pkt_done ignored.
- Reset mid-operation: all state discarded; no pulses emitted.

Decomposition:
- Shared package bpf_sched_pkg: core state enum (FREE, FILL, RUN, DONE), verdict encoding constants.
- One natural sub-module, bpf_order_fifo: parametrised index FIFO (depth, width) with push/pop/head/empty.
- Per-core FSM + watchdog via generate loop in the top.

Test Plan:
1. N_CORES=4 after reset: alloc_valid=1 and wr_idx=0 by cycle 2; pkt_done len=64 -> core_start=4'b0001 next cycle, core_len[0]=64, wr_idx=1 once alloc_valid reasserts.
2. Packets A (core0), B (core1); core_acc[1] before core_rej[0] -> res_valid only after core0's verdict: first res_idx=0 res_acc=0, then res_idx=1 res_acc=1.
3. TIMEOUT_CYCLES=16, started core never answers -> core_abort pulses 16 cycles after core_start; res_acc=0; timeout_cnt=1.
4. Fill all 4 cores -> alloc_valid=0 and extra pkt_done ignored; one res handshake -> freed core index reappears on wr_idx two cycles later.
5. pkt_len=0 -> no core_start; res_valid with res_acc=0, res_len=0; simultaneous acc+rej on another core -> res_acc=0.
6. Assert rst low mid-run with res_valid high -> all outputs 0 immediately (async); after release, allocation restarts at wr_idx=0.
